// File: rtl/serial_pkg.sv
// Constants and types shared by the serial-bus master and slave.
// Frame layout, LSB first on the wire: {start, payload[15:0], checksum}.
package serial_pkg;

    localparam int         FRAME_W     = 32;
    localparam int         CNT_W       = $clog2(FRAME_W);
    localparam logic [7:0] START       = 8'hAA;
    localparam logic [7:0] MASTER_ADDR = 8'h00;
    localparam logic [7:0] OK          = 8'h01;
    localparam logic [7:0] FAIL        = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RX    = 3'd2,
        ST_CHECK = 3'd3,
        ST_TX    = 3'd4
    } slave_state_t;

    // Event counters stick at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/slave_if.sv
// Request strobe and local-sink status of the serial slave.
// The shared data line itself stays a plain inout pin on the top.
interface slave_if;

    logic        req;
    logic [15:0] data_out;
    logic        data_valid;
    logic        chk_err;
    logic        busy;
    logic [7:0]  ok_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output req,
        input  data_out, data_valid, chk_err, busy, ok_cnt, err_cnt
    );

    modport slave (
        input  req,
        output data_out, data_valid, chk_err, busy, ok_cnt, err_cnt
    );

endinterface

// File: rtl/frame_checksum.sv
// Carry-free 8-bit checksum: bitwise XOR of two bytes.
module frame_checksum (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_ck
);

    assign o_ck = i_a ^ i_b;

endmodule

// File: rtl/slave.sv
// Serial responder: receives a 32-bit request frame, validates it, hands the
// payload to the local sink and answers with a 32-bit status frame.
//
// state  | meaning
// IDLE   | line released, waiting for req
// ARM    | one cycle aligned with the master's init cycle, clears bit counter
// RX     | shifts in 32 bits, LSB first
// CHECK  | validates start byte and checksum, line still released
// TX     | drives status frame bits 0..31
module slave
    import serial_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    inout  wire    serial,
    slave_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

    slave_state_t       r_state;
    slave_state_t       w_state_nxt;

    logic [FRAME_W-1:0] r_rx;
    logic [FRAME_W-1:0] r_tx;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_data;
    logic               r_valid;
    logic               r_err;
    logic [7:0]         r_ok_cnt;
    logic [7:0]         r_err_cnt;

    logic [7:0]         w_ck;
    logic [7:0]         w_status;
    logic [7:0]         w_reply_ck;
    logic               w_start_ok;
    logic               w_ck_ok;
    logic               w_last;

    frame_checksum u_rx_ck (
        .i_a  (r_rx[23:16]),
        .i_b  (r_rx[15:8]),
        .o_ck (w_ck)
    );

    frame_checksum u_reply_ck (
        .i_a  (MASTER_ADDR),
        .i_b  (w_status),
        .o_ck (w_reply_ck)
    );

    assign w_start_ok = (r_rx[31:24] == START);
    assign w_ck_ok    = (w_ck == r_rx[7:0]);
    assign w_status   = w_ck_ok ? OK : FAIL;
    assign w_last     = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.req) w_state_nxt = ST_ARM;
            ST_ARM:   w_state_nxt = ST_RX;
            ST_RX:    if (w_last) w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = w_start_ok ? ST_TX : ST_IDLE;
            ST_TX:    if (w_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx      <= '0;
            r_tx      <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    r_cnt <= '0;
                end
                ST_RX: begin
                    r_rx  <= {serial, r_rx[FRAME_W-1:1]};
                    r_cnt <= r_cnt + CNT_ONE;
                end
                ST_CHECK: begin
                    r_cnt <= '0;
                    // A frame without a valid start byte is silently dropped.
                    if (w_start_ok) begin
                        r_tx <= {START, MASTER_ADDR, w_status, w_reply_ck};
                        if (w_ck_ok) begin
                            r_data   <= r_rx[23:8];
                            r_valid  <= 1'b1;
                            r_ok_cnt <= sat_inc8(r_ok_cnt);
                        end else begin
                            r_err     <= 1'b1;
                            r_err_cnt <= sat_inc8(r_err_cnt);
                        end
                    end
                end
                ST_TX: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (w_last) r_tx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Driven purely from registers, so the line is released the moment
    // reset or the end of TX clears the state.
    assign serial = (r_state == ST_TX) ? r_tx[r_cnt] : 1'bz;

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.chk_err    = r_err;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ok_cnt     = r_ok_cnt;
    assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_slave.sv
// Directed bench for the serial slave: the bench plays the master, sends
// frames bit by bit and checks pulses, counters and the reply frame.
module tb_slave;
    import serial_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic r_drv_en;
    logic r_drv_bit;
    wire  serial;

    int total = 0;
    int bad   = 0;

    assign serial = r_drv_en ? r_drv_bit : 1'bz;

    slave_if bus ();

    slave dut (
        .clk    (clk),
        .reset  (reset),
        .serial (serial),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in cycle T, returns in cycle T+67. When no reply is expected the
    // bench keeps the line driven low, so any slave drive of a 1 shows up.
    task automatic do_frame(input logic [31:0] f, input bit expect_tx, input bit poke_req,
                            output logic [31:0] reply, output int n_valid, output int n_err,
                            output logic busy_t1, output logic busy_t35);
        reply   = '0;
        n_valid = 0;
        n_err   = 0;
        bus.req   = 1'b1;
        r_drv_en  = 1'b1;
        r_drv_bit = 1'b0;
        tick();
        bus.req = 1'b0;
        busy_t1 = bus.busy;
        tick();
        for (int i = 0; i < 32; i++) begin
            r_drv_bit = f[i];
            tick();
        end
        r_drv_bit = 1'b0;
        n_valid += int'(bus.data_valid);
        n_err   += int'(bus.chk_err);
        tick();
        busy_t35 = bus.busy;
        if (expect_tx) r_drv_en = 1'b0;
        for (int j = 0; j < 32; j++) begin
            reply[j] = serial;
            n_valid += int'(bus.data_valid);
            n_err   += int'(bus.chk_err);
            bus.req = (poke_req && j == 10);
            tick();
        end
        bus.req   = 1'b0;
        r_drv_en  = 1'b1;
        r_drv_bit = 1'b0;
    endtask

    logic [31:0] reply;
    int          n_valid;
    int          n_err;
    logic        busy_t1;
    logic        busy_t35;
    logic [15:0] pl;
    logic [31:0] fr;
    logic [7:0]  exp_ok;

    initial begin
        reset     = 1'b1;
        bus.req   = 1'b0;
        r_drv_en  = 1'b1;
        r_drv_bit = 1'b0;
        repeat (3) tick();
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_valid",    32'(bus.data_valid), 32'h0);
        check("rst_chk_err",  32'(bus.chk_err), 32'h0);
        check("rst_busy",     32'(bus.busy), 32'h0);
        check("rst_ok_cnt",   32'(bus.ok_cnt), 32'h0);
        check("rst_err_cnt",  32'(bus.err_cnt), 32'h0);
        reset = 1'b0;
        repeat (2) tick();

        do_frame(32'hAA123426, 1'b1, 1'b0, reply, n_valid, n_err, busy_t1, busy_t35);
        check("good_busy_arm", 32'(busy_t1), 32'h1);
        check("good_busy_t35", 32'(busy_t35), 32'h1);
        check("good_reply",    reply, 32'hAA000101);
        check("good_valid_n",  32'(n_valid), 32'd1);
        check("good_err_n",    32'(n_err), 32'd0);
        check("good_data_out", 32'(bus.data_out), 32'h1234);
        check("good_ok_cnt",   32'(bus.ok_cnt), 32'd1);
        check("good_idle_end", 32'(bus.busy), 32'h0);

        do_frame(32'hAA123427, 1'b1, 1'b0, reply, n_valid, n_err, busy_t1, busy_t35);
        check("badck_reply",    reply, 32'hAA000000);
        check("badck_valid_n",  32'(n_valid), 32'd0);
        check("badck_err_n",    32'(n_err), 32'd1);
        check("badck_data_out", 32'(bus.data_out), 32'h1234);
        check("badck_err_cnt",  32'(bus.err_cnt), 32'd1);
        check("badck_ok_cnt",   32'(bus.ok_cnt), 32'd1);

        do_frame(32'h55123426, 1'b0, 1'b0, reply, n_valid, n_err, busy_t1, busy_t35);
        check("badst_line",    reply, 32'h0);
        check("badst_valid_n", 32'(n_valid), 32'd0);
        check("badst_err_n",   32'(n_err), 32'd0);
        check("badst_idle35",  32'(busy_t35), 32'h0);
        check("badst_ok_cnt",  32'(bus.ok_cnt), 32'd1);
        check("badst_err_cnt", 32'(bus.err_cnt), 32'd1);

        // Reset mid-RX at T+20.
        fr = 32'hAA123426;
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        for (int i = 0; i < 18; i++) begin
            r_drv_bit = fr[i];
            tick();
        end
        r_drv_bit = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_busy",     32'(bus.busy), 32'h0);
        check("midrst_ok_cnt",   32'(bus.ok_cnt), 32'h0);
        check("midrst_err_cnt",  32'(bus.err_cnt), 32'h0);
        check("midrst_data_out", 32'(bus.data_out), 32'h0);
        check("midrst_line",     32'(serial), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        do_frame(32'hAABEEF51, 1'b1, 1'b0, reply, n_valid, n_err, busy_t1, busy_t35);
        check("beef_reply",    reply, 32'hAA000101);
        check("beef_valid_n",  32'(n_valid), 32'd1);
        check("beef_data_out", 32'(bus.data_out), 32'hBEEF);
        check("beef_ok_cnt",   32'(bus.ok_cnt), 32'd1);
        check("beef_err_cnt",  32'(bus.err_cnt), 32'd0);

        // 256 back-to-back good frames; last one pokes req during TX.
        for (int k = 1; k <= 256; k++) begin
            pl = 16'(k) ^ 16'h5A3C;
            fr = {8'hAA, pl, pl[15:8] ^ pl[7:0]};
            do_frame(fr, 1'b1, (k == 256), reply, n_valid, n_err, busy_t1, busy_t35);
            exp_ok = (k >= 254) ? 8'd255 : 8'(k + 1);
            if (k == 100 || k == 253 || k == 254 || k == 256) begin
                check($sformatf("b2b_ok_cnt_%0d", k), 32'(bus.ok_cnt), 32'(exp_ok));
                check($sformatf("b2b_reply_%0d", k), reply, 32'hAA000101);
            end
        end
        check("b2b_data_out", 32'(bus.data_out), 32'(16'(256) ^ 16'h5A3C));
        check("poke_idle_end", 32'(bus.busy), 32'h0);
        repeat (5) tick();
        check("poke_ignored", 32'(bus.busy), 32'h0);
        check("sat_ok_cnt",   32'(bus.ok_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave.md
# slave

Serial responder on the single-wire `serial` bus, directly downstream of `master`. Samples the master's 32-bit request frame (start byte, 16-bit payload, checksum), validates it, presents the payload to the local sink, and drives a 32-bit status frame back on the same wire. Release of the line outside its transmit window is mandatory.

## Interface
- `FRAME_W`, 32: frame length in bits; fixed, not to be overridden.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `serial`  inout  1  shared bidirectional data line, LSB first; driven only in TX, else `1'bz`.
- `req`  in  1  frame-start strobe from `master` output `r` (1-cycle pulse).
- `data_out`  out  16  last accepted payload; reset 0.
- `data_valid`  out  1  1-cycle pulse when `data_out` updates; reset 0.
- `chk_err`  out  1  1-cycle pulse on checksum mismatch; reset 0.
- `busy`  out  1  high in every state except IDLE; reset 0.
- `ok_cnt`  out  8  accepted-frame count, saturates at 255; reset 0.
- `err_cnt`  out  8  checksum-error count, saturates at 255; reset 0.

## Operation
- States: IDLE, ARM, RX, CHECK, TX.
- IDLE: `req`=1 -> ARM; otherwise stay.
- ARM: one cycle, aligned with the master's init cycle; clear bit counter -> RX.
- RX: each cycle, shift `rx = {serial, rx[31:1]}`. Bit counter 0..31; at 31 -> CHECK.
- After RX, `rx[31:24]`=start, `rx[23:8]`=payload, `rx[7:0]`=checksum.
- CHECK, single cycle:
  - `rx[31:24]` != 8'hAA -> IDLE. No reply is sent and no pulses are issued.
  - Otherwise compute `ck = rx[23:16] ^ rx[15:8]`. This is bitwise and carry-free, matching the master's 1-bit sums.
  - If `ck == rx[7:0]`: `data_out <= rx[23:8]`, pulse `data_valid`, increment `ok_cnt`, load `tx = {8'hAA, 8'h00, 8'h01, 8'h01}`.
  - Else: pulse `chk_err`, increment `err_cnt`, load `tx = {8'hAA, 8'h00, 8'h00, 8'h00}`.
  - Reply checksum = master address ^ status = status.
  - -> TX.
- TX: `serial = tx[cnt]`, bit counter 0..31; at 31 -> IDLE and clear `tx`.
- `req` outside IDLE is ignored; no queueing.
- Counters saturate and never wrap.

## Timing
- `req` high in cycle T. ARM at T+1. RX samples bits 0..31 in T+2..T+33. CHECK at T+34, which coincides with the master's waiting cycle; the line is released. TX drives bits 0..31 in T+35..T+66. IDLE at T+67.
- `serial` is driven from the registered state only, so it cannot glitch onto the bus during CHECK.
- `data_valid`/`chk_err` are registered and assert in cycle T+35.
- Earliest next accepted `req` is at T+67.
- Asynchronous reset, any state: state -> IDLE, counters and outputs -> 0, `serial` released immediately, partial frame discarded.

## Structure
- Shared package `serial_pkg` holds the constants common with `master`:
  - `START`=8'hAA, `MASTER_ADDR`=8'h00, `OK`=8'h01, `FAIL`=8'h00, `FRAME_W`=32.
  - Slave state typedef/encoding.
- One sub-module, `frame_checksum`: combinational 8-bit XOR of two bytes. It is reused by `master` for both generation and check.

## Test plan
- Payload 0x1234 (frame 0xAA123426) -> `data_out`=0x1234, `data_valid` pulse at T+35, reply 0xAA000101 on T+35..T+66, `ok_cnt`=1; master asserts `ok`.
- Frame 0xAA123427 (bad checksum) -> `chk_err` pulse, no `data_valid`, `data_out` unchanged, reply 0xAA000000, `err_cnt`=1.
- Frame 0x55123426 (bad start) -> no pulses, `serial` stays Z through T+35..T+66, back in IDLE at T+35; master reports `noAnswer`.
- `reset` asserted at T+20 (mid-RX) -> immediate IDLE, line Z, counters 0; the next `req` with payload 0xBEEF (frame 0xAABEEF51) completes normally.
- 256 good frames back-to-back -> `ok_cnt` holds 255; a `req` pulse during TX is ignored.
